fetch_unit: RTL and testbench

Instruction fetch stage. Generates sequential PCs, issues word reads to instruction memory over a valid/ready request channel, and buffers in-order responses. It presents {instruction, PC} pairs to the decode stage over a valid/ready handshake. Control-flow redirects from execute flush the buffer and discard in-flight wrong-path responses.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 78 +++++++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, word width,
// PC step and small PC helper functions.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_INC           = 32'd4;

    typedef logic [31:0] pc_t;

    // Sequential successor of a PC; wraps naturally at 32 bits.
    function automatic pc_t next_pc(input pc_t pc);
        return pc + PC_INC;
    endfunction

    // Force a target PC onto a word boundary.
    function automatic pc_t align_pc(input pc_t pc);
        return pc & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// In-order instruction buffer. Clear wins over push/pop; push to a full
// buffer and pop from an empty buffer are ignored.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = INST_W
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign do_push_s = push_i & (count_q != FULL_CNT);
    assign do_pop_s  = pop_i & (count_q != '0);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + CW'(do_push_s) - CW'(do_pop_s);
        end
    end

    // Storage and pointer registers; storage zeroed on reset so the head reads 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s && !clear_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, credit-limited request
// issue, in-order response buffering and redirect-driven flush with
// wrong-path response discard.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT_LIM = (CW + 1)'(DEPTH);

    logic          rst_state_q;
    pc_t           fetch_pc_q, fetch_pc_d;
    pc_t           head_pc_q, head_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;

    logic [CW-1:0] fifo_count_s;
    logic [31:0]   fifo_head_s;
    logic [CW:0]   credit_sum_s;
    logic          req_fire_s;
    logic          rsp_take_s;
    logic          push_s;
    logic          pop_s;
    pc_t           redir_tgt_s;

    // Request issue uses registered counts only, so valid never depends on ready.
    assign credit_sum_s   = {1'b0, outstanding_q} + {1'b0, fifo_count_s};
    assign imem_req_valid = ~rst_state_q & (credit_sum_s < CREDIT_LIM);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire_s     = imem_req_valid & imem_req_ready;

    // Responses with nothing outstanding are stale (e.g. from before reset) and dropped.
    assign rsp_take_s  = imem_rsp_valid & (outstanding_q != '0);
    assign push_s      = rsp_take_s & (discard_q == '0) & ~redirect_valid;

    assign out_valid   = (fifo_count_s != '0) & ~redirect_valid;
    assign out_inst    = fifo_head_s;
    assign out_pc      = head_pc_q;
    assign pop_s       = out_valid & out_ready;
    assign redir_tgt_s = align_pc(redirect_pc);

    // PC, credit and discard next-state; a redirect overrides everything else.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_pc_d     = head_pc_q;
        discard_d     = discard_q;
        outstanding_d = outstanding_q + CW'(req_fire_s) - CW'(rsp_take_s);
        if (redirect_valid) begin
            fetch_pc_d = redir_tgt_s;
            head_pc_d  = redir_tgt_s;
            discard_d  = outstanding_d;
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = next_pc(fetch_pc_q);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (pop_s) begin
                head_pc_d = next_pc(head_pc_q);
            end else begin
                head_pc_d = head_pc_q;
            end
            if (rsp_take_s && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end else begin
                discard_d = discard_q;
            end
        end
    end

    // State registers; the reset-hold bit delays the first request by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_state_q   <= 1'b1;
            fetch_pc_q    <= RESET_PC;
            head_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else begin
            rst_state_q   <= 1'b0;
            fetch_pc_q    <= fetch_pc_d;
            head_pc_q     <= head_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (redirect_valid),
        .push_i  (push_s),
        .data_i  (imem_rsp_data),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count_s)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a cycle table from reset, hand sequences for
// redirect and reset corner cases, and a variable-latency memory run checked
// against a sequential PC reference.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    int passed = 0;
    int total  = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        rst;
        logic        ready;
        logic        rsp_v;
        logic [31:0] rsp_addr;
        logic        out_ready;
        logic        e_req_v;
        logic [31:0] e_addr;
        logic        e_out_v;
        logic [31:0] e_pc;
        logic        chk_inst;
        logic [31:0] e_inst;
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    // Memory contents: invertible scramble of the address, never equal to 0 at 0.
    function automatic logic [31:0] memw(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
    endfunction

    function automatic vec_t mk(input logic r, input logic rdy, input logic rv,
                                input logic [31:0] ra, input logic ordy,
                                input logic erv, input logic [31:0] ea,
                                input logic eov, input logic [31:0] epc,
                                input logic ci, input logic [31:0] ei);
        vec_t v;
        v.rst = r; v.ready = rdy; v.rsp_v = rv; v.rsp_addr = ra; v.out_ready = ordy;
        v.e_req_v = erv; v.e_addr = ea; v.e_out_v = eov; v.e_pc = epc;
        v.chk_inst = ci; v.e_inst = ei;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic set_in(input logic rdy, input logic rv, input logic [31:0] ra,
                          input logic rd, input logic [31:0] rp, input logic ordy);
        imem_req_ready = rdy;
        imem_rsp_valid = rv;
        imem_rsp_data  = rv ? memw(ra) : 32'hDEAD_BEEF;
        redirect_valid = rd;
        redirect_pc    = rp;
        out_ready      = ordy;
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        adv();
        rst = 1'b0;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        adv();
    endtask

    vec_t  tbl [19];
    pend_t pq [$];

    initial begin
        int          cyc;
        int          idle;
        int          delivered;
        logic [31:0] exp_pc;
        logic        rdy, ordy, rd;
        logic [31:0] rp;
        pend_t       p;

        // rst, ready, rsp_v, rsp_addr, out_ready | req_v, addr, out_v, out_pc, chk_inst, inst
        tbl[0]  = mk(1, 1, 0, 32'h00, 1,  0, 32'h00, 0, 32'h00, 1, 32'h0);
        tbl[1]  = mk(0, 1, 0, 32'h00, 1,  0, 32'h00, 0, 32'h00, 1, 32'h0);
        tbl[2]  = mk(0, 1, 0, 32'h00, 1,  1, 32'h00, 0, 32'h00, 0, 32'h0);
        tbl[3]  = mk(0, 1, 1, 32'h00, 1,  1, 32'h04, 0, 32'h00, 0, 32'h0);
        tbl[4]  = mk(0, 1, 1, 32'h04, 1,  0, 32'h08, 1, 32'h00, 1, memw(32'h00));
        tbl[5]  = mk(0, 1, 0, 32'h00, 1,  1, 32'h08, 1, 32'h04, 1, memw(32'h04));
        tbl[6]  = mk(0, 1, 1, 32'h08, 1,  1, 32'h0C, 0, 32'h08, 0, 32'h0);
        tbl[7]  = mk(0, 1, 1, 32'h0C, 0,  0, 32'h10, 1, 32'h08, 1, memw(32'h08));
        tbl[8]  = mk(0, 1, 0, 32'h00, 0,  0, 32'h10, 1, 32'h08, 1, memw(32'h08));
        tbl[9]  = mk(0, 1, 0, 32'h00, 0,  0, 32'h10, 1, 32'h08, 1, memw(32'h08));
        tbl[10] = mk(0, 1, 0, 32'h00, 1,  0, 32'h10, 1, 32'h08, 1, memw(32'h08));
        tbl[11] = mk(0, 1, 0, 32'h00, 1,  1, 32'h10, 1, 32'h0C, 1, memw(32'h0C));
        tbl[12] = mk(0, 1, 1, 32'h10, 1,  1, 32'h14, 0, 32'h10, 0, 32'h0);
        tbl[13] = mk(0, 1, 1, 32'h14, 1,  0, 32'h18, 1, 32'h10, 1, memw(32'h10));
        tbl[14] = mk(0, 0, 0, 32'h00, 1,  1, 32'h18, 1, 32'h14, 1, memw(32'h14));
        tbl[15] = mk(0, 0, 0, 32'h00, 1,  1, 32'h18, 0, 32'h18, 0, 32'h0);
        tbl[16] = mk(0, 1, 0, 32'h00, 1,  1, 32'h18, 0, 32'h18, 0, 32'h0);
        tbl[17] = mk(0, 1, 1, 32'h18, 1,  1, 32'h1C, 0, 32'h18, 0, 32'h0);
        tbl[18] = mk(0, 1, 1, 32'h1C, 1,  0, 32'h20, 1, 32'h18, 1, memw(32'h18));

        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        adv();

        // Table: reset, streaming, backpressure hold and request stalls.
        for (int i = 0; i < 19; i++) begin
            rst = tbl[i].rst;
            set_in(tbl[i].ready, tbl[i].rsp_v, tbl[i].rsp_addr, 1'b0, 32'h0, tbl[i].out_ready);
            chk($sformatf("tbl%0d_req_valid", i), imem_req_valid, tbl[i].e_req_v);
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].e_addr);
            chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_out_v);
            chk($sformatf("tbl%0d_out_pc", i), out_pc, tbl[i].e_pc);
            if (tbl[i].chk_inst) begin
                chk($sformatf("tbl%0d_out_inst", i), out_inst, tbl[i].e_inst);
            end
            adv();
        end

        // Redirect with two requests in flight, then redirects colliding with
        // a returning response and an accepted request.
        do_reset();
        set_in(1'b0, 1'b0, 32'h0, 1'b1, 32'h10, 1'b1);
        chk("rd_unaccepted_valid", imem_req_valid, 1'b1);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_addr_0x10", imem_req_addr, 32'h10);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_addr_0x14", imem_req_addr, 32'h14);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b1, 32'h103, 1'b1);
        chk("rd_full_credit", imem_req_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b1, 32'h10, 1'b0, 32'h0, 1'b1);
        chk("rd_drop1_valid", imem_req_valid, 1'b0);
        adv();
        set_in(1'b0, 1'b1, 32'h14, 1'b0, 32'h0, 1'b1);
        chk("rd_new_addr", imem_req_addr, 32'h100);
        chk("rd_new_valid", imem_req_valid, 1'b1);
        chk("rd_drop_no_out", out_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_addr_hold", imem_req_addr, 32'h100);
        adv();
        set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'h0, 1'b1);
        chk("rd_lat_out_valid", out_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        chk("rd_first_valid", out_valid, 1'b1);
        chk("rd_first_pc", out_pc, 32'h100);
        chk("rd_first_inst", out_inst, memw(32'h100));
        chk("rd_next_addr", imem_req_addr, 32'h104);
        adv();
        set_in(1'b1, 1'b1, 32'h104, 1'b1, 32'h200, 1'b1);
        chk("rd_redir_masks_out", out_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_flushed", out_valid, 1'b0);
        chk("rd_head_0x200", out_pc, 32'h200);
        chk("rd_addr_0x200", imem_req_addr, 32'h200);
        adv();
        set_in(1'b1, 1'b1, 32'h200, 1'b1, 32'h303, 1'b1);
        chk("rd_coll_addr", imem_req_addr, 32'h204);
        chk("rd_coll_valid", imem_req_valid, 1'b1);
        chk("rd_coll_no_out", out_valid, 1'b0);
        adv();
        set_in(1'b0, 1'b1, 32'h204, 1'b0, 32'h0, 1'b1);
        chk("rd_coll_new_addr", imem_req_addr, 32'h300);
        chk("rd_coll_new_valid", imem_req_valid, 1'b1);
        chk("rd_coll_discard", out_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        set_in(1'b0, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        chk("rd_coll_wait", out_valid, 1'b0);
        adv();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rd_coll_out_valid", out_valid, 1'b1);
        chk("rd_coll_out_pc", out_pc, 32'h300);
        chk("rd_coll_out_inst", out_inst, memw(32'h300));
        adv();

        // Reset with two responses in flight: stale responses must vanish.
        do_reset();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_addr0", imem_req_addr, 32'h0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_addr4", imem_req_addr, 32'h4);
        adv();
        rst = 1'b1;
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        adv();
        rst = 1'b0;
        set_in(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_req_valid", imem_req_valid, 1'b0);
        chk("rs_req_addr", imem_req_addr, 32'h0);
        chk("rs_out_valid", out_valid, 1'b0);
        chk("rs_out_pc", out_pc, 32'h0);
        chk("rs_out_inst", out_inst, 32'h0);
        adv();
        set_in(1'b0, 1'b1, 32'h4, 1'b0, 32'h0, 1'b1);
        chk("rs_restart_valid", imem_req_valid, 1'b1);
        chk("rs_restart_addr", imem_req_addr, 32'h0);
        chk("rs_stale_dropped", out_valid, 1'b0);
        adv();
        set_in(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_stale_dropped2", out_valid, 1'b0);
        adv();
        set_in(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_wait", out_valid, 1'b0);
        adv();
        set_in(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        chk("rs_first_valid", out_valid, 1'b1);
        chk("rs_first_pc", out_pc, 32'h0);
        chk("rs_first_inst", out_inst, memw(32'h0));
        adv();

        // Variable latency 1-4, random stalls and redirects vs sequential reference.
        do_reset();
        pq.delete();
        exp_pc    = 32'h0;
        cyc       = 0;
        idle      = 0;
        delivered = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i < 1400) begin
                rdy  = ($urandom_range(0, 9) < 7);
                ordy = ($urandom_range(0, 9) < 7);
                rd   = ($urandom_range(0, 39) == 0);
            end else begin
                rdy  = 1'b1;
                ordy = 1'b1;
                rd   = 1'b0;
            end
            rp = $urandom;
            if (pq.size() > 0 && pq[0].due <= cyc) begin
                p = pq.pop_front();
                set_in(rdy, 1'b1, p.addr, rd, rp, ordy);
            end else begin
                set_in(rdy, 1'b0, 32'h0, rd, rp, ordy);
            end
            if (rd) begin
                chk("rand_redir_out_valid", out_valid, 1'b0);
            end
            if (out_valid && out_ready) begin
                chk("rand_out_pc", out_pc, exp_pc);
                chk("rand_out_inst", out_inst, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
                delivered++;
                idle = 0;
            end else begin
                idle++;
            end
            if (rd) begin
                exp_pc = rp & 32'hFFFF_FFFC;
            end
            if (imem_req_valid && imem_req_ready) begin
                p.addr = imem_req_addr;
                p.due  = cyc + $urandom_range(1, 4);
                pq.push_back(p);
            end
            if (idle > 200) begin
                total++;
                $display("FAIL rand_stall: got %0d idle cycles expected at most 200", idle);
                break;
            end
            adv();
            cyc++;
        end
        chk("rand_delivered_min", (delivered >= 100), 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
